// File: rtl/dac_play_seq_pkg.sv
// Shared definitions for the DAC playback sequencer: state encoding and GPIO control bit map.
package dac_play_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PLAY  = 2'd2,
        FLUSH = 2'd3
    } seq_state_t;

    // gpio_ctrl bit indices; the driver edge-detects these into single-cycle pulses
    localparam int GPIO_ADC_BUFFER_FLUSH = 0;
    localparam int GPIO_DAC_ARM          = 1;
    localparam int GPIO_DAC_ABORT        = 2;

endpackage

// File: rtl/dac_play_seq_trig_edge_det.sv
// Single-register rising-edge detector; also reused by the driver for the GPIO arm/abort pulses.
module dac_play_seq_trig_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    // Combinational so the edge adds no latency beyond the one register
    assign rise = level & ~level_q;

endmodule

// File: rtl/dac_play_seq.sv
// DAC playback sequencer: load, arm, triggered looped playback with beat/repetition counting, flush.
module dac_play_seq
    import dac_play_seq_pkg::*;
#(
    parameter int LEN_W = 16,
    parameter int REP_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             abort,
    input  logic             trigger_in,
    input  logic [LEN_W-1:0] wave_len,
    input  logic [REP_W-1:0] rep_count,
    input  logic             beat_fire,
    input  logic             fifo_empty,
    output logic             mux_sel,
    output logic             play_en,
    output logic             flush,
    output logic             busy,
    output logic             done,
    output logic             len_err,
    output logic [REP_W-1:0] reps_done
);

    seq_state_t       state, state_n;
    logic [LEN_W-1:0] len_m1, len_m1_n;
    logic [LEN_W-1:0] beat_cnt, beat_cnt_n;
    logic [REP_W-1:0] rep_lat, rep_lat_n;
    logic [REP_W-1:0] reps_n, reps_inc;
    logic             len_err_n;
    logic             done_n;
    logic             trig_rise;

    dac_play_seq_trig_edge_det u_trig (
        .clk   (clk),
        .rst   (rst),
        .level (trigger_in),
        .rise  (trig_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        len_m1_n   = len_m1;
        beat_cnt_n = beat_cnt;
        rep_lat_n  = rep_lat;
        reps_n     = reps_done;
        len_err_n  = len_err;
        done_n     = 1'b0;
        reps_inc   = (&reps_done) ? reps_done : reps_done + REP_W'(1);

        case (state)
            IDLE: begin
                if (abort) begin
                    state_n = FLUSH;
                end else if (arm) begin
                    if (wave_len != '0) begin
                        len_m1_n  = wave_len - LEN_W'(1);
                        rep_lat_n = rep_count;
                        len_err_n = 1'b0;
                        state_n   = ARMED;
                    end else begin
                        len_err_n = 1'b1;
                    end
                end
            end
            ARMED: begin
                if (abort) begin
                    state_n = FLUSH;
                end else if (trig_rise) begin
                    beat_cnt_n = '0;
                    reps_n     = '0;
                    state_n    = PLAY;
                end
            end
            PLAY: begin
                if (abort) begin
                    state_n = FLUSH;
                end else if (beat_fire) begin
                    if (beat_cnt == len_m1) begin
                        beat_cnt_n = '0;
                        reps_n     = reps_inc;
                        // FIFO still holds the waveform, so park in ARMED for a retrigger
                        if ((rep_lat != '0) && (reps_inc == rep_lat)) begin
                            state_n = ARMED;
                            done_n  = 1'b1;
                        end
                    end else begin
                        beat_cnt_n = beat_cnt + LEN_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (fifo_empty) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every output is a flop
    always_ff @(posedge clk) begin
        if (rst) begin
            len_m1    <= '0;
            beat_cnt  <= '0;
            rep_lat   <= '0;
            reps_done <= '0;
            len_err   <= 1'b0;
            done      <= 1'b0;
            mux_sel   <= 1'b0;
            play_en   <= 1'b0;
            flush     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            len_m1    <= len_m1_n;
            beat_cnt  <= beat_cnt_n;
            rep_lat   <= rep_lat_n;
            reps_done <= reps_n;
            len_err   <= len_err_n;
            done      <= done_n;
            mux_sel   <= (state_n == ARMED) || (state_n == PLAY);
            play_en   <= (state_n == PLAY);
            flush     <= (state_n == FLUSH);
            busy      <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_dac_play_seq.sv
// Self-checking bench for dac_play_seq: vector table, directed corner sequences, random traffic vs model.
module tb_dac_play_seq;

    localparam bit N = 1'b0;
    localparam bit Y = 1'b1;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_PLAY  = 2;
    localparam int M_FLUSH = 3;

    logic        clk = 1'b0;
    logic        rst, arm, abort, trigger_in, beat_fire, fifo_empty;
    logic [15:0] wave_len, rep_count;
    logic        mux_sel, play_en, flush, busy, done, len_err;
    logic [15:0] reps_done;

    int tests = 0;
    int fails = 0;

    // Reference model: playback tracked as a total beat count since the trigger
    int     m_mode;
    bit     m_tprev;
    int     m_len, m_rep, m_reps;
    longint m_total;
    bit     m_lerr, m_done;

    typedef struct {
        logic        rst, arm, abort, trig, beat, fe;
        logic [15:0] wl, rc;
        logic [5:0]  exp_flags;
        logic [15:0] exp_reps;
    } vec_t;

    vec_t tbl[14];

    always #5 clk = ~clk;

    dac_play_seq #(.LEN_W(16), .REP_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .abort      (abort),
        .trigger_in (trigger_in),
        .wave_len   (wave_len),
        .rep_count  (rep_count),
        .beat_fire  (beat_fire),
        .fifo_empty (fifo_empty),
        .mux_sel    (mux_sel),
        .play_en    (play_en),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .len_err    (len_err),
        .reps_done  (reps_done)
    );

    function automatic vec_t row(input bit r, input bit a, input bit ab, input bit t,
                                 input bit b, input bit f, input logic [15:0] wl,
                                 input logic [15:0] rc, input logic [5:0] fl,
                                 input logic [15:0] reps);
        vec_t v;
        v.rst = r; v.arm = a; v.abort = ab; v.trig = t; v.beat = b; v.fe = f;
        v.wl = wl; v.rc = rc; v.exp_flags = fl; v.exp_reps = reps;
        return v;
    endfunction

    function automatic logic [21:0] dut_vec();
        return {mux_sel, play_en, flush, busy, done, len_err, reps_done};
    endfunction

    function automatic logic [21:0] model_vec();
        logic [15:0] r;
        r = m_reps[15:0];
        return {(m_mode == M_ARMED) || (m_mode == M_PLAY), m_mode == M_PLAY,
                m_mode == M_FLUSH, m_mode != M_IDLE, m_done, m_lerr, r};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit rise;
        if (rst) begin
            m_mode = M_IDLE; m_tprev = 0; m_total = 0; m_reps = 0;
            m_lerr = 0; m_done = 0; m_len = 0; m_rep = 0;
            return;
        end
        rise    = trigger_in && !m_tprev;
        m_tprev = trigger_in;
        m_done  = 0;
        if (abort && m_mode != M_FLUSH) begin
            m_mode = M_FLUSH;
        end else begin
            case (m_mode)
                M_IDLE: if (arm) begin
                    if (wave_len != 0) begin
                        m_len = int'(wave_len); m_rep = int'(rep_count);
                        m_lerr = 0; m_mode = M_ARMED;
                    end else begin
                        m_lerr = 1;
                    end
                end
                M_ARMED: if (rise) begin
                    m_total = 0; m_reps = 0; m_mode = M_PLAY;
                end
                M_PLAY: if (beat_fire) begin
                    m_total++;
                    m_reps = int'((m_total / m_len > 65535) ? 65535 : m_total / m_len);
                    if (m_rep != 0 && m_total == longint'(m_len) * m_rep) begin
                        m_done = 1; m_mode = M_ARMED;
                    end
                end
                default: if (fifo_empty) m_mode = M_IDLE;
            endcase
        end
    endtask

    // One clock: model advances on the same edge, then outputs are compared 1 ns later
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        checkOutput("model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic applyStimulus(input vec_t v);
        rst = v.rst; arm = v.arm; abort = v.abort; trigger_in = v.trig;
        beat_fire = v.beat; fifo_empty = v.fe; wave_len = v.wl; rep_count = v.rc;
        tick();
    endtask

    task automatic pulse_arm(input logic [15:0] wl, input logic [15:0] rc);
        wave_len = wl; rep_count = rc; arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t required below 1ms", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int beats, dones;

        // flags: {mux_sel, play_en, flush, busy, done, len_err}
        tbl[0]  = row(N,N,Y,N,N,N, 16'd0, 16'd0, 6'b001100, 16'd2);
        tbl[1]  = row(N,N,N,N,N,N, 16'd0, 16'd0, 6'b001100, 16'd2);
        tbl[2]  = row(N,N,N,N,N,Y, 16'd0, 16'd0, 6'b000000, 16'd2);
        tbl[3]  = row(N,Y,N,N,N,N, 16'd0, 16'd0, 6'b000001, 16'd2);
        tbl[4]  = row(N,N,N,N,N,N, 16'd0, 16'd0, 6'b000001, 16'd2);
        tbl[5]  = row(N,Y,N,N,N,N, 16'd3, 16'd1, 6'b100100, 16'd2);
        tbl[6]  = row(N,N,N,Y,N,N, 16'd3, 16'd1, 6'b110100, 16'd0);
        tbl[7]  = row(N,N,N,Y,Y,N, 16'd0, 16'd0, 6'b110100, 16'd0);
        tbl[8]  = row(N,N,N,N,Y,N, 16'd0, 16'd0, 6'b110100, 16'd0);
        tbl[9]  = row(N,N,N,Y,N,N, 16'd0, 16'd0, 6'b110100, 16'd0);
        tbl[10] = row(N,Y,N,Y,Y,N, 16'd0, 16'd0, 6'b100110, 16'd1);
        tbl[11] = row(N,N,N,N,N,N, 16'd0, 16'd0, 6'b100100, 16'd1);
        tbl[12] = row(N,N,Y,Y,N,N, 16'd0, 16'd0, 6'b001100, 16'd1);
        tbl[13] = row(N,N,N,N,N,Y, 16'd0, 16'd0, 6'b000000, 16'd1);

        rst = 1'b1; arm = 1'b0; abort = 1'b0; trigger_in = 1'b0;
        beat_fire = 1'b0; fifo_empty = 1'b0; wave_len = '0; rep_count = '0;
        tick();
        tick();
        checkOutput("reset_outputs", 32'(dut_vec()), 32'd0);
        rst = 1'b0;

        // wave_len=4, rep_count=2 with beat_fire held high
        pulse_arm(16'd4, 16'd2);
        checkOutput("armed_mux_play_busy", {29'd0, mux_sel, play_en, busy}, 32'b101);
        trigger_in = 1'b1;
        tick();
        checkOutput("trigger_play_en", {31'd0, play_en}, 32'd1);
        beat_fire = 1'b1;
        beats = 0;
        dones = 0;
        for (int g = 0; g < 40 && play_en; g++) begin
            tick();
            beats++;
            if (done) dones++;
        end
        checkOutput("play_beats", beats, 32'd8);
        checkOutput("done_pulses", dones, 32'd1);
        checkOutput("reps_after_two", {16'd0, reps_done}, 32'd2);
        checkOutput("back_to_armed", {29'd0, mux_sel, play_en, busy}, 32'b101);
        beat_fire = 1'b0;
        trigger_in = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("vec%0d_flags", i),
                        {26'd0, mux_sel, play_en, flush, busy, done, len_err},
                        {26'd0, tbl[i].exp_flags});
            checkOutput($sformatf("vec%0d_reps", i), {16'd0, reps_done}, {16'd0, tbl[i].exp_reps});
        end
        applyStimulus(row(N,N,N,N,N,N, 16'd0, 16'd0, 6'b000000, 16'd1));

        // rep_count=0, wave_len=1: endless playback until abort
        pulse_arm(16'd1, 16'd0);
        trigger_in = 1'b1;
        tick();
        beat_fire = 1'b1;
        repeat (1000) tick();
        checkOutput("endless_reps", {16'd0, reps_done}, 32'd1000);
        checkOutput("endless_play_en", {31'd0, play_en}, 32'd1);
        abort = 1'b1;
        beat_fire = 1'b0;
        tick();
        abort = 1'b0;
        checkOutput("abort_flush", {30'd0, flush, play_en}, 32'b10);
        repeat (3) tick();
        checkOutput("flush_held", {31'd0, flush}, 32'd1);
        fifo_empty = 1'b1;
        tick();
        checkOutput("flush_exit_idle", {29'd0, mux_sel, flush, busy}, 32'd0);
        fifo_empty = 1'b0;
        trigger_in = 1'b0;
        tick();

        // abort coincides with the final beat_fire
        pulse_arm(16'd2, 16'd1);
        trigger_in = 1'b1;
        tick();
        beat_fire = 1'b1;
        tick();
        abort = 1'b1;
        tick();
        checkOutput("abort_vs_final", {29'd0, flush, done, play_en}, 32'b100);
        abort = 1'b0;
        beat_fire = 1'b0;
        fifo_empty = 1'b1;
        tick();
        fifo_empty = 1'b0;
        trigger_in = 1'b0;
        tick();

        // rst mid-PLAY with beat_fire held
        pulse_arm(16'd5, 16'd0);
        trigger_in = 1'b1;
        tick();
        beat_fire = 1'b1;
        repeat (7) tick();
        checkOutput("pre_rst_reps", {16'd0, reps_done}, 32'd1);
        rst = 1'b1;
        tick();
        checkOutput("rst_mid_play", 32'(dut_vec()), 32'd0);
        rst = 1'b0;
        repeat (2) tick();
        checkOutput("post_rst_beats_ignored", 32'(dut_vec()), 32'd0);
        beat_fire = 1'b0;
        trigger_in = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 299) == 0);
            arm        = ($urandom_range(0, 7) == 0);
            abort      = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) trigger_in = ~trigger_in;
            beat_fire  = ($urandom_range(0, 1) == 0);
            fifo_empty = ($urandom_range(0, 2) == 0);
            wave_len   = 16'($urandom_range(0, 4));
            rep_count  = 16'($urandom_range(0, 3));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
